// File: rtl/booth_pkg.sv
// Shared types and the Booth digit decoder for the booth_seq_mul slice.
// Optional accumulate mode in booth_seq_mul is enabled by the BOOTH_ACC_EN macro.
package booth_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        ZERO = 3'd0,
        POS1 = 3'd1,
        POS2 = 3'd2,
        NEG1 = 3'd3,
        NEG2 = 3'd4
    } booth_op_t;

    // Radix-4 recoding of the triplet {b[2k+1], b[2k], b[2k-1]}.
    function automatic booth_op_t booth_decode(input logic [2:0] digit);
        booth_op_t op;
        case (digit)
            3'b001, 3'b010: op = POS1;
            3'b011:         op = POS2;
            3'b100:         op = NEG2;
            3'b101, 3'b110: op = NEG1;
            default:        op = ZERO;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/booth_pp_gen.sv
// Combinational Booth partial-product generator: selects 0, +a, +2a, -a or -2a
// at 2*WIDTH bits from one 3-bit digit and the sign-extended multiplicand.
module booth_pp_gen
    import booth_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [2:0]         digit,
    input  logic [2*WIDTH-1:0] a_ext,
    output logic [2*WIDTH-1:0] pp
);

    localparam logic [2*WIDTH-1:0] ONE = {{(2*WIDTH-1){1'b0}}, 1'b1};

    logic [2*WIDTH-1:0] a_dbl;

    assign a_dbl = a_ext << 1;

    // Pick the multiple of a; negation is two's complement at full product width.
    always_comb begin
        pp = '0;
        case (booth_decode(digit))
            POS1:    pp = a_ext;
            POS2:    pp = a_dbl;
            NEG1:    pp = ~a_ext + ONE;
            NEG2:    pp = ~a_dbl + ONE;
            default: pp = '0;
        endcase
    end

endmodule

// File: rtl/booth_seq_mul.sv
// Sequential radix-4 Booth signed multiplier, one digit per clock.
// Define BOOTH_ACC_EN to add the acc_clr port and a running 2*WIDTH accumulator.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are both
// high. in_ready is high only in IDLE, out_valid only in DONE; neither depends
// combinationally on the opposite side's valid/ready inputs.
module booth_seq_mul
    import booth_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
`ifdef BOOTH_ACC_EN
    input  logic               acc_clr,
`endif
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] product,
    output state_t             dbg_state
);

    localparam int DIGITS = WIDTH / 2;
    localparam int KW     = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(DIGITS - 1);

    state_t             state_q, state_d;
    logic [KW-1:0]      k_q;
    logic [WIDTH-1:0]   a_q, b_q;
    logic [2*WIDTH-1:0] sum_q, sum_next, sum_start;
    logic [2*WIDTH-1:0] a_ext, pp, pp_shifted;
    logic [WIDTH:0]     b_ext;
    logic [2:0]         digit;
    logic               last_digit;

    // b[-1] = 0 is supplied by the appended zero, so every triplet is in range.
    assign a_ext      = {{WIDTH{a_q[WIDTH-1]}}, a_q};
    assign b_ext      = {b_q, 1'b0};
    assign digit      = 3'(b_ext >> {k_q, 1'b0});
    assign pp_shifted = pp << {k_q, 1'b0};
    assign sum_next   = sum_q + pp_shifted;
    assign last_digit = (k_q == K_LAST);
    assign dbg_state  = state_q;

    booth_pp_gen #(.WIDTH(WIDTH)) u_pp_gen (
        .digit (digit),
        .a_ext (a_ext),
        .pp    (pp)
    );

`ifdef BOOTH_ACC_EN
    logic [2*WIDTH-1:0] acc_q;

    assign sum_start = acc_clr ? '0 : acc_q;

    // Accumulator follows the final sum of each operation.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q <= '0;
        end else if (state_q == BUSY && last_digit) begin
            acc_q <= sum_next;
        end
    end
`else
    assign sum_start = '0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_d = BUSY;
            end
            BUSY: begin
                if (last_digit) state_d = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Operand capture, digit counter, running sum and product register.
    always_ff @(posedge clk) begin
        if (reset) begin
            a_q     <= '0;
            b_q     <= '0;
            k_q     <= '0;
            sum_q   <= '0;
            product <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q   <= a;
                        b_q   <= b;
                        k_q   <= '0;
                        sum_q <= sum_start;
                    end
                end
                BUSY: begin
                    sum_q <= sum_next;
                    k_q   <= k_q + 1'b1;
                    if (last_digit) product <= sum_next;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_booth_seq_mul.sv
// Bench for booth_seq_mul: directed WIDTH=8 scenarios plus randomized
// back-to-back streams on WIDTH=4 and WIDTH=16 instances.
module tb_booth_seq_mul;
    import booth_pkg::*;

    int tests = 0;
    int fails = 0;

    logic clk = 1'b0;
    logic reset = 1'b1;

    // WIDTH = 8 instance
    logic        iv8 = 0, ir8, ov8, or8 = 0, ac8 = 1;
    logic [7:0]  a8 = 0, b8 = 0;
    logic [15:0] p8;
    state_t      st8;
    // WIDTH = 4 instance
    logic        iv4 = 0, ir4, ov4, or4 = 0, ac4 = 1;
    logic [3:0]  a4 = 0, b4 = 0;
    logic [7:0]  p4;
    state_t      st4;
    // WIDTH = 16 instance
    logic        iv16 = 0, ir16, ov16, or16 = 0, ac16 = 1;
    logic [15:0] a16 = 0, b16 = 0;
    logic [31:0] p16;
    state_t      st16;

    logic [31:0] exp_q[$];
    logic [15:0] acc_m = '0;

    booth_seq_mul #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
`ifdef BOOTH_ACC_EN
        .acc_clr(ac8),
`endif
        .out_valid(ov8), .out_ready(or8), .product(p8), .dbg_state(st8)
    );

    booth_seq_mul #(.WIDTH(4)) dut4 (
        .clk(clk), .reset(reset), .in_valid(iv4), .in_ready(ir4), .a(a4), .b(b4),
`ifdef BOOTH_ACC_EN
        .acc_clr(ac4),
`endif
        .out_valid(ov4), .out_ready(or4), .product(p4), .dbg_state(st4)
    );

    booth_seq_mul #(.WIDTH(16)) dut16 (
        .clk(clk), .reset(reset), .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16),
`ifdef BOOTH_ACC_EN
        .acc_clr(ac16),
`endif
        .out_valid(ov16), .out_ready(or16), .product(p16), .dbg_state(st16)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // reference: plain signed multiplication, truncated to the product width
    function automatic logic [15:0] mul8(input int x, input int y);
        logic signed [7:0] sx, sy;
        int p;
        sx = x[7:0];
        sy = y[7:0];
        p = int'(sx) * int'(sy);
        return p[15:0];
    endfunction

    // expected product for one WIDTH=8 operation, including accumulate mode
    function automatic logic [15:0] model8(input int x, input int y, input logic clr);
`ifdef BOOTH_ACC_EN
        if (clr) acc_m = mul8(x, y);
        else     acc_m = acc_m + mul8(x, y);
        return acc_m;
`else
        return mul8(x, y);
`endif
    endfunction

    task automatic wait_done8(output int lat);
        lat = 0;
        while (!ov8 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    // driver: one complete WIDTH=8 operation with latency and return-to-idle checks
    task automatic do_op8(input string tag, input int x, input int y, input logic clr);
        logic [15:0] e;
        int lat;
        e = model8(x, y, clr);
        @(negedge clk);
        a8 = x[7:0]; b8 = y[7:0]; ac8 = clr; iv8 = 1;
        check({tag, "_in_ready"}, 32'(ir8), 32'd1);
        @(posedge clk); #1;
        iv8 = 0;
        a8 = 8'($urandom); b8 = 8'($urandom);
        wait_done8(lat);
        check({tag, "_latency"}, 32'(lat), 32'd4);
        check({tag, "_product"}, 32'(p8), 32'(e));
        or8 = 1;
        @(posedge clk); #1;
        or8 = 0;
        check({tag, "_idle_after"}, 32'(ir8), 32'd1);
        check({tag, "_ov_low"}, 32'(ov8), 32'd0);
        ac8 = 1;
    endtask

    // driver + scoreboard: back-to-back stream on the WIDTH=4 instance
    task automatic stream4(input int n);
        int sent, got, cyc;
        logic acc;
        logic [31:0] e;
        sent = 0; got = 0; cyc = 0;
        exp_q.delete();
        @(posedge clk); #1;
        or4 = 1; a4 = 4'($urandom); b4 = 4'($urandom); iv4 = 1;
        while (got < n && cyc < n * 12) begin
            @(negedge clk);
            if (ov4) begin
                check("w4_not_dup", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("w4_product", 32'(p4), e);
                end
                got++;
            end
            acc = iv4 && ir4;
            if (acc) begin
                int sa, sb, p;
                sa = int'($signed(a4)); sb = int'($signed(b4)); p = sa * sb;
                exp_q.push_back(32'(p[7:0]));
            end
            @(posedge clk); #1;
            cyc++;
            if (acc) begin
                sent++;
                a4 = 4'($urandom); b4 = 4'($urandom);
                iv4 = (sent < n);
            end
        end
        iv4 = 0; or4 = 0;
        check("w4_count", 32'(got), 32'(n));
        check("w4_queue_empty", 32'(exp_q.size()), 32'd0);
    endtask

    // driver + scoreboard: back-to-back stream on the WIDTH=16 instance
    task automatic stream16(input int n);
        int sent, got, cyc;
        logic acc;
        logic [31:0] e;
        sent = 0; got = 0; cyc = 0;
        exp_q.delete();
        @(posedge clk); #1;
        or16 = 1; a16 = 16'($urandom); b16 = 16'($urandom); iv16 = 1;
        while (got < n && cyc < n * 20) begin
            @(negedge clk);
            if (ov16) begin
                check("w16_not_dup", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("w16_product", p16, e);
                end
                got++;
            end
            acc = iv16 && ir16;
            if (acc) begin
                longint sa, sb, p;
                sa = longint'($signed(a16)); sb = longint'($signed(b16)); p = sa * sb;
                exp_q.push_back(p[31:0]);
            end
            @(posedge clk); #1;
            cyc++;
            if (acc) begin
                sent++;
                a16 = 16'($urandom); b16 = 16'($urandom);
                iv16 = (sent < n);
            end
        end
        iv16 = 0; or16 = 0;
        check("w16_count", 32'(got), 32'(n));
        check("w16_queue_empty", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        logic [15:0] e;
        int lat;

        // reset
        repeat (3) @(posedge clk);
        #1 reset = 0;
        check("rst_in_ready", 32'(ir8), 32'd1);
        check("rst_out_valid", 32'(ov8), 32'd0);
        check("rst_product", 32'(p8), 32'd0);
        check("rst_state", 32'(st8), 32'(IDLE));
        check("rst_product_w16", p16, 32'd0);

        // directed products, including the most negative operands
        do_op8("mul_7_m3", 7, -3, 1'b1);
        check("mul_7_m3_const", 32'(p8), 32'h0000_FFEB);
        do_op8("mul_m128_m128", -128, -128, 1'b1);
        check("mul_m128_m128_const", 32'(p8), 32'h0000_4000);
        do_op8("mul_m128_127", -128, 127, 1'b1);
        check("mul_m128_127_const", 32'(p8), 32'h0000_C080);
        do_op8("mul_m1_m1", -1, -1, 1'b1);
        do_op8("mul_0_m77", 0, -77, 1'b1);

        // backpressure in DONE, with in_valid held high against in_ready low
        e = model8(9, -6, 1'b1);
        @(negedge clk);
        a8 = 8'd9; b8 = 8'hFA; ac8 = 1; iv8 = 1;
        @(posedge clk); #1;
        a8 = 8'd5; b8 = 8'd5;
        wait_done8(lat);
        check("bp_latency", 32'(lat), 32'd4);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check("bp_product", 32'(p8), 32'(e));
            check("bp_out_valid", 32'(ov8), 32'd1);
            check("bp_in_ready", 32'(ir8), 32'd0);
        end
        or8 = 1;
        @(posedge clk); #1;
        or8 = 0;
        check("bp_release_idle", 32'(st8), 32'(IDLE));
        check("bp_release_ov", 32'(ov8), 32'd0);
        e = model8(5, 5, 1'b1);
        @(posedge clk); #1;
        iv8 = 0;
        check("bp_accept_next_idle", 32'(st8), 32'(BUSY));
        wait_done8(lat);
        check("bp_second_product", 32'(p8), 32'(e));
        or8 = 1;
        @(posedge clk); #1;
        or8 = 0;

        // reset in the middle of BUSY
        @(negedge clk);
        a8 = 8'd11; b8 = 8'd13; iv8 = 1;
        @(posedge clk); #1;
        iv8 = 0;
        @(posedge clk); #1;
        reset = 1;
        @(posedge clk); #1;
        reset = 0;
        acc_m = '0;
        check("midrst_in_ready", 32'(ir8), 32'd1);
        check("midrst_out_valid", 32'(ov8), 32'd0);
        check("midrst_product", 32'(p8), 32'd0);
        repeat (3) begin
            @(posedge clk); #1;
            check("midrst_no_result", 32'(ov8), 32'd0);
        end
        do_op8("after_rst_3x5", 3, 5, 1'b1);
        check("after_rst_3x5_const", 32'(p8), 32'd15);

`ifdef BOOTH_ACC_EN
        // accumulate mode
        do_op8("acc_clr_3x4", 3, 4, 1'b1);
        check("acc_clr_3x4_const", 32'(p8), 32'd12);
        do_op8("acc_add_m2x5", -2, 5, 1'b0);
        check("acc_add_m2x5_const", 32'(p8), 32'd2);
`endif

        // randomized back-to-back streams
        stream4(200);
        stream16(200);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/booth_seq_mul.md
# booth_seq_mul

Parametrised sequential radix-4 (modified Booth) signed multiplier with valid/ready handshakes on both sides. It retires one Booth digit per clock, so a WIDTH x WIDTH product takes WIDTH/2 cycles. It sits between operand-producing logic and the BIST result compactor, replacing fixed 4-bit multipliers that have no handshake.

## Interface
- WIDTH, 8, operand width in bits; even, >= 4
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- in_valid  in  1  operands a/b present
- in_ready  out  1  block idle and can accept; high only in IDLE
- a  in  WIDTH  multiplicand, two's complement
- b  in  WIDTH  multiplier, two's complement
- acc_clr  in  1  present only with BOOTH_ACC_EN; sampled with operands
- out_valid  out  1  product valid; high only in DONE
- out_ready  in  1  consumer takes product
- product  out  2*WIDTH  signed result

## Operation
- FSM states and transitions:
  - IDLE -> BUSY on in_valid && in_ready. The accepting edge latches a, b, and acc_clr, clears the digit counter k to 0, and clears the working sum to 0 (or loads the held accumulator, see Configuration).
  - BUSY: each edge adds pp_k << 2k to the sum and increments k. After digit k = WIDTH/2-1 the FSM goes to DONE.
  - DONE: product holds; DONE -> IDLE on out_ready.
- Booth digit k is {b[2k+1], b[2k], b[2k-1]}, with b[-1] = 0:
  - 000, 111 -> 0
  - 001, 010 -> +a
  - 011 -> +2a
  - 100 -> -2a
  - 101, 110 -> -a
- Width rules:
  - a is sign-extended to 2*WIDTH bits before doubling or negating.
  - Negation is ~x+1 at 2*WIDTH width.
  - All adds are modulo 2^(2*WIDTH).
  - Every digit index is in range; there are no out-of-range bit selects and no X assignments.
- Full range is exact, including (-2^(W-1)) x (-2^(W-1)) = 2^(2W-2).
- product updates only on entry to DONE and otherwise holds its last value.
- Operand inputs are ignored outside IDLE.

## Timing
- Reset values: in_ready = 1 (state IDLE), out_valid = 0, product = 0, k = 0, accumulator = 0.
- Latency: acceptance at edge E0 gives out_valid high after edge E(WIDTH/2). For WIDTH = 8, that is 4 cycles.
- Throughput: one result per WIDTH/2 + 2 cycles when out_ready is held high. There is one IDLE cycle between operations.
- Backpressure: with out_ready low, DONE holds indefinitely and product stays stable.
- DONE with out_ready high and in_valid high: no accept in that cycle, because in_ready is low. The accept happens in the following IDLE cycle.
- Reset mid-operation (BUSY or DONE): abort at the next edge, return to IDLE, and apply all reset values. A partial result is never presented.
- in_valid held without acceptance has no effect outside IDLE.

## Configuration
- BOOTH_ACC_EN defined:
  - acc_clr port exists and a 2*WIDTH accumulator is kept.
  - On accept, the sum starts at 0 if acc_clr = 1, else at the current accumulator.
  - On DONE entry, accumulator and product both take the new sum.
  - Wrap is modulo 2^(2*WIDTH).
  - Reset clears the accumulator.
- Undefined: no acc_clr port, and product = a*b on every operation.

## Structure
- Shared package booth_pkg holds:
  - enum state_t {IDLE, BUSY, DONE}
  - enum booth_op_t {ZERO, POS1, POS2, NEG1, NEG2}
  - the function mapping a 3-bit digit to booth_op_t
- Sub-module booth_pp_gen, combinational:
  - inputs: 3-bit digit, sign-extended a
  - output: 2*WIDTH partial product
  - instantiated once, indexed by k
- Top holds the FSM, counter, operand registers, adder, and accumulator.

## Test plan
- WIDTH = 8, a = 7, b = -3 -> product 0xFFEB (-21), out_valid 4 cycles after accept.
- WIDTH = 8, a = -128, b = -128 -> 0x4000; a = -128, b = 127 -> 0xC080 (-16256).
- Hold out_ready low 10 cycles in DONE -> product and out_valid stable, in_ready low; release -> IDLE next edge.
- Assert reset at BUSY cycle 2 -> after the next edge: in_ready 1, out_valid 0, product 0; a fresh 3 x 5 then gives 15.
- WIDTH = 4 and 16, 200 random signed pairs, back-to-back with out_ready high -> match reference a*b with no dropped or duplicated results.
- BOOTH_ACC_EN, WIDTH = 8: (acc_clr = 1, 3 x 4), then (acc_clr = 0, -2 x 5) -> product 12, then 2.
